// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: rebuilds pixel coordinates and data-enable
// from sampled sync/blank strobes, and verifies line/frame totals to report lock.
module vga_sync_decoder #(
   parameter int H_TOTAL     = 1056,
   parameter int V_TOTAL     = 628,
   parameter int LOCK_FRAMES = 2,
   parameter int TIMEOUT     = 2112
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic        de,
   output logic        frame_start,
   output logic        locked,
   output logic        line_err,
   output logic        frame_err,
   output logic [7:0]  err_cnt
);

   typedef enum logic [1:0] {UNLOCKED, CHECKING, LOCKED} state_t;

   localparam logic [12:0] H_TOT   = 13'(H_TOTAL);
   localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);
   localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
   localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

   logic        hs_r, vs_r, hb_r, vb_r;
   logic        hs_d, vs_d, hb_d;
   logic        hs_rise, vs_rise, hb_rise, act;
   logic [11:0] hcnt;
   logic [10:0] lcnt, x_cnt, y_cnt;
   logic        h_seen, lerr_seen;
   logic [12:0] period;
   logic        h_to, line_err_c, frame_err_c, err_c;
   logic [3:0]  good, good_nxt, good_inc;
   state_t      state, state_nxt;
   logic        unlock, lk_nxt;
   logic [8:0]  err_sum;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         hs_r <= 1'b0; vs_r <= 1'b0; hb_r <= 1'b0; vb_r <= 1'b0;
         hs_d <= 1'b0; vs_d <= 1'b0; hb_d <= 1'b0;
      end else begin
         hs_r <= hsync_in; vs_r <= vsync_in; hb_r <= hblnk_in; vb_r <= vblnk_in;
         hs_d <= hs_r;     vs_d <= vs_r;     hb_d <= hb_r;
      end
   end

   assign hs_rise = hs_r & ~hs_d;
   assign vs_rise = vs_r & ~vs_d;
   assign hb_rise = hb_r & ~hb_d;
   assign act     = ~hb_r & ~vb_r;

   // hcnt is cleared by the edge itself, so the period includes the edge cycle
   assign period      = {1'b0, hcnt} + 13'd1;
   assign h_to        = (hcnt == TO_LAST) & ~hs_rise;
   assign line_err_c  = (hs_rise & h_seen & (period != H_TOT)) | h_to;
   assign frame_err_c = vs_rise & (state != UNLOCKED) & (lcnt != V_TOT);
   assign err_c       = line_err_c | frame_err_c;
   assign good_inc    = good + 4'd1;

   always_comb begin
      state_nxt = state;
      good_nxt  = good;
      if (h_to) begin
         state_nxt = UNLOCKED;
         good_nxt  = '0;
      end else begin
         case (state)
            UNLOCKED: begin
               if (vs_rise) begin
                  state_nxt = CHECKING;
                  good_nxt  = '0;
               end
            end
            CHECKING: begin
               if (err_c) begin
                  good_nxt = '0;
               end else if (vs_rise && !lerr_seen) begin
                  good_nxt = good_inc;
                  if (good_inc >= LOCK_N) state_nxt = LOCKED;
               end
            end
            LOCKED: begin
               if (err_c) begin
                  state_nxt = UNLOCKED;
                  good_nxt  = '0;
               end
            end
            default: begin
               state_nxt = UNLOCKED;
               good_nxt  = '0;
            end
         endcase
      end
   end

   assign unlock  = (state != UNLOCKED) && (state_nxt == UNLOCKED);
   assign lk_nxt  = (state_nxt == LOCKED);
   assign err_sum = {1'b0, err_cnt} + {8'd0, line_err_c} + {8'd0, frame_err_c};

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= UNLOCKED;
         good  <= '0;
      end else begin
         state <= state_nxt;
         good  <= good_nxt;
      end
   end

   // Timing measurement: line period, line count per frame, first-edge tracking
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt      <= '0;
         lcnt      <= '0;
         h_seen    <= 1'b0;
         lerr_seen <= 1'b0;
      end else begin
         if (hs_rise)               hcnt <= '0;
         else if (hcnt != 12'hFFF)  hcnt <= hcnt + 12'd1;

         // a line starting on the vsync edge belongs to the new frame
         if (vs_rise)                         lcnt <= hs_rise ? 11'd1 : 11'd0;
         else if (hs_rise && lcnt != 11'h7FF) lcnt <= lcnt + 11'd1;

         if (h_to || unlock) h_seen <= 1'b0;
         else if (hs_rise)   h_seen <= 1'b1;

         if (vs_rise)         lerr_seen <= 1'b0;
         else if (line_err_c) lerr_seen <= 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
         pix_x <= '0;
         pix_y <= '0;
      end else begin
         if (hb_r) begin
            x_cnt <= '0;
         end else if (!vb_r) begin
            pix_x <= x_cnt;
            if (x_cnt != 11'h7FF) x_cnt <= x_cnt + 11'd1;
         end

         if (vb_r)                             y_cnt <= '0;
         else if (hb_rise && y_cnt != 11'h7FF) y_cnt <= y_cnt + 11'd1;

         if (act) pix_y <= y_cnt;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         de          <= 1'b0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         line_err    <= 1'b0;
         frame_err   <= 1'b0;
         err_cnt     <= '0;
      end else begin
         de          <= act & lk_nxt;
         frame_start <= vs_rise;
         locked      <= lk_nxt;
         line_err    <= line_err_c;
         frame_err   <= frame_err_c;
         err_cnt     <= err_sum[8] ? 8'hFF : err_sum[7:0];
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a scaled-down timing generator with fault
// injection, a pixel scoreboard, and lock/error event checks.
module tb_vga_sync_decoder;

   localparam int H_TOTAL = 40, H_ACT = 32, HS0 = 34, HS1 = 38;
   localparam int V_TOTAL = 12, V_ACT = 8,  VS0 = 9,  VS1 = 11;
   localparam int LOCK_FRAMES = 2, TIMEOUT = 80;
   localparam int F = H_TOTAL * V_TOTAL;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [10:0] pix_x, pix_y;
   logic        de, frame_start, locked, line_err, frame_err;
   logic [7:0]  err_cnt;

   vga_sync_decoder #(
      .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT(TIMEOUT)
   ) dut (
      .pclk(pclk), .rst_n(rst_n),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .pix_x(pix_x), .pix_y(pix_y), .de(de), .frame_start(frame_start), .locked(locked),
      .line_err(line_err), .frame_err(frame_err), .err_cnt(err_cnt)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct packed {
      logic        chk;
      logic        act;
      logic [10:0] x;
      logic [10:0] y;
   } exp_t;
   exp_t sbq[$];

   int n_chk = 0, n_pass = 0;
   int hc = 0, vc = 0;
   bit sb_en, short_req, drop_req, mute, vs_arm, hs_prev, lk_prev, lk_seen, le_lock, fe_lock;
   int vs_cyc, hs_cyc, lk_cyc, le_gap, le_n, fe_n, fs_n;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // one pclk: observe outputs of two drives ago, then drive the next sample
   task automatic step();
      exp_t e;
      bit   hs;
      @(negedge pclk);
      if (sbq.size() >= 2) begin
         e = sbq.pop_front();
         if (e.chk) begin
            chk("de", int'(de), int'(e.act));
            if (e.act) begin
               chk("pix_x", int'(pix_x), int'(e.x));
               chk("pix_y", int'(pix_y), int'(e.y));
            end
         end
      end
      if (line_err)  begin le_n++; le_lock = locked; le_gap = cyc - hs_cyc; end
      if (frame_err) begin fe_n++; fe_lock = locked; end
      if (frame_start) fs_n++;
      if (locked && !lk_prev) begin lk_seen = 1; lk_cyc = cyc; end
      lk_prev = locked;

      hs = (hc >= HS0) && (hc < HS1) && !(mute && vc >= 1 && vc <= 4);
      if (hs && !hs_prev) hs_cyc = cyc;
      hs_prev = hs;
      if (vs_arm && vc == VS0 && hc == 0) begin vs_cyc = cyc; vs_arm = 0; end
      hsync_in = hs;
      vsync_in = (vc >= VS0) && (vc < VS1);
      hblnk_in = (hc >= H_ACT);
      vblnk_in = (vc >= V_ACT);
      e.chk = sb_en;
      e.act = !hblnk_in && !vblnk_in;
      e.x   = 11'(hc);
      e.y   = 11'(vc);
      sbq.push_back(e);

      hc++;
      if (short_req && hc == 36) begin hc = 37; short_req = 0; end
      if (hc == H_TOTAL) begin
         hc = 0;
         vc++;
         if (drop_req && vc == 4) begin vc = 5; drop_req = 0; end
         if (vc == V_TOTAL) vc = 0;
      end
   endtask

   task automatic align();
      while (!(hc == 0 && vc == 0)) step();
   endtask

   task automatic wait_lock(input string tag);
      int n = 0;
      lk_seen = 0;
      vs_arm  = 1;
      while (!lk_seen && n < 6 * F) begin step(); n++; end
      chk({tag, "_seen"}, int'(lk_seen), 1);
      if (lk_seen) chk({tag, "_time"}, lk_cyc - vs_cyc, 2 * F + 2);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pix_x"}, int'(pix_x), 0);
      chk({tag, "_pix_y"}, int'(pix_y), 0);
      chk({tag, "_de"}, int'(de), 0);
      chk({tag, "_fs"}, int'(frame_start), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_line_err"}, int'(line_err), 0);
      chk({tag, "_frame_err"}, int'(frame_err), 0);
      chk({tag, "_err_cnt"}, int'(err_cnt), 0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge pclk);
      chk_zero("rst");
      rst_n = 1'b1;
      le_n = 0; fe_n = 0;

      // clean timing from reset
      wait_lock("lock0");
      chk("lock0_le", le_n, 0);
      chk("lock0_fe", fe_n, 0);

      // one full locked frame through the pixel scoreboard
      align();
      sb_en = 1; fs_n = 0;
      repeat (F) step();
      sb_en = 0;
      repeat (2) step();
      chk("fs_per_frame", fs_n, 1);
      chk("clean_le", le_n, 0);
      chk("clean_fe", fe_n, 0);
      chk("clean_cnt", int'(err_cnt), 0);

      // one line shortened by a cycle
      chk("short_pre_lock", int'(locked), 1);
      le_n = 0; fe_n = 0;
      while (!(hc == 0 && vc == 2)) step();
      short_req = 1;
      repeat (3 * H_TOTAL) step();
      chk("short_le", le_n, 1);
      chk("short_lock", int'(le_lock), 0);
      chk("short_fe", fe_n, 0);
      chk("short_cnt", int'(err_cnt), 1);
      wait_lock("relock_short");

      // one frame missing a line
      chk("drop_pre_lock", int'(locked), 1);
      le_n = 0; fe_n = 0;
      align();
      drop_req = 1;
      n = 0;
      while (fe_n == 0 && n < 2 * F) begin step(); n++; end
      chk("drop_fe", fe_n, 1);
      chk("drop_lock", int'(fe_lock), 0);
      chk("drop_le", le_n, 0);
      chk("drop_cnt", int'(err_cnt), 2);
      wait_lock("relock_drop");

      // hsync lost for four lines
      chk("to_pre_lock", int'(locked), 1);
      le_n = 0; fe_n = 0;
      align();
      mute = 1;
      while (vc < 5) step();
      mute = 0;
      chk("to_le", le_n, 1);
      chk("to_gap", le_gap, TIMEOUT + 2);
      chk("to_lock", int'(le_lock), 0);
      chk("to_cnt", int'(err_cnt), 3);
      wait_lock("relock_to");
      chk("to_le_after", le_n, 1);
      chk("to_fe_after", fe_n, 0);

      // asynchronous reset in the middle of an active line
      while (!(hc == 10 && vc == 1)) step();
      chk("rst_pre_lock", int'(locked), 1);
      @(posedge pclk);
      #2 rst_n = 1'b0;
      #1 chk_zero("arst");
      repeat (3) step();
      rst_n = 1'b1;
      le_n = 0; fe_n = 0;
      wait_lock("lock_rst");
      repeat (F) step();
      chk("rst_le", le_n, 0);
      chk("rst_fe", fe_n, 0);
      chk("rst_cnt", int'(err_cnt), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the 800x600@60 timing generator.
- Samples incoming hsync/vsync/hblnk/vblnk at 40 MHz and regenerates pixel coordinates plus a data-enable.
- Checks line and frame timing against the VESA totals; reports lock status and timing errors.
- Sits at the input of any video consumer: frame grabber, overlay checker, or the verification monitor for the generator.

Parameters:
- H_TOTAL, 1056, expected pclk cycles between consecutive hsync rising edges
- V_TOTAL, 628, expected hsync rising edges between consecutive vsync rising edges
- LOCK_FRAMES, 2, consecutive good frames required to assert locked (1..15)
- TIMEOUT, 2112, pclk cycles without an hsync rising edge that flags a lost signal

Ports:
- pclk, input, 1: pixel clock, 40 MHz
- rst_n, input, 1: asynchronous active-low reset
- hsync_in, input, 1: horizontal sync, active high
- vsync_in, input, 1: vertical sync, active high
- hblnk_in, input, 1: horizontal blank, active high
- vblnk_in, input, 1: vertical blank, active high
- pix_x, output, 11: column of current active pixel
- pix_y, output, 11: row of current active line
- de, output, 1: active pixel and locked
- frame_start, output, 1: one-cycle pulse on vsync rising edge
- locked, output, 1: timing verified
- line_err, output, 1: one-cycle pulse on bad line length or timeout
- frame_err, output, 1: one-cycle pulse on bad line count
- err_cnt, output, 8: saturating error count

Behaviour:
- Reset (async, rst_n=0): all outputs 0; internal counters 0; FSM UNLOCKED; first-edge flags cleared. Applies immediately, including mid-frame.
- Input stage: all four inputs registered once. Rising edges are detected on the registered copy against its previous value. Outputs are registered, so total latency is 2 pclk from input to pix_x/pix_y/de/frame_start.
- hcnt (12 bit): increments every cycle, saturating at 4095.
  - On hsync rise: measured period = hcnt+1, then hcnt<=0.
  - The first hsync rise after reset or unlock is not checked.
  - Otherwise, if the period differs from H_TOTAL, pulse line_err.
- Timeout: if hcnt reaches TIMEOUT-1, pulse line_err exactly once and go to UNLOCKED. No further pulse until the next hsync rise.
- lcnt (11 bit): increments on each hsync rise.
  - On vsync rise: compare lcnt to V_TOTAL, except on the first vsync rise after reset or unlock.
  - Mismatch pulses frame_err.
  - lcnt then reloads to 0, or to 1 if an hsync rise occurs in the same cycle (that line belongs to the new frame).
- frame_start: pulses on every vsync rise, in any state.
- pix_x: x_cnt<=0 while hblnk=1. While hblnk=0 and vblnk=0, pix_x<=x_cnt and x_cnt increments, saturating at 2047.
- pix_y: y_cnt<=0 while vblnk=1. On hblnk rise with vblnk=0, y_cnt increments, saturating at 2047. pix_y<=y_cnt.
- pix_x and pix_y hold their last value outside the active area.
- de = (hblnk=0 & vblnk=0) & locked, aligned with pix_x/pix_y.
- FSM:
  - UNLOCKED: first vsync rise -> CHECKING, good=0.
  - CHECKING: vsync rise with correct lcnt and no line_err since previous vsync -> good+1. When good reaches LOCK_FRAMES -> LOCKED, and locked=1 from the next cycle. Any line_err or frame_err -> good=0, stay CHECKING.
  - LOCKED: any line_err or frame_err -> UNLOCKED, locked=0 in the same cycle as the error pulse.
  - Timeout from any state -> UNLOCKED.
- Error priority: line_err and frame_err in the same cycle are both pulsed and err_cnt adds 2. err_cnt saturates at 255 and clears only on reset.

Test Plan:
- Drive standard generator timing (1056x628) from reset -> locked rises 2 full frames (1326336 pclk) after the first vsync rise, plus 2 cycles. Thereafter no line_err/frame_err; err_cnt=0.
- Locked, one active line: pix_x 0..799 with de=1 for 800 consecutive cycles. pix_y counts 0..599 per frame, and pix_y=0 on the first active line after frame_start.
- Locked, shorten one line to 1055 cycles -> single line_err pulse; locked drops in that cycle; err_cnt=1. Relock after 1 vsync plus 2 good frames.
- Locked, deliver a frame with 627 lines -> frame_err at that vsync rise; locked=0; err_cnt increments by 1.
- Stop hsync while locked -> exactly one line_err at hcnt=2111; locked=0. Restore hsync -> no check on the first edge, relock as in the first test.
- Assert rst_n=0 mid-line for 3 cycles -> all outputs 0 asynchronously. After release, the first hsync/vsync are unchecked and no spurious errors occur.
